// File: rtl/digit_serial_alu_if.sv
// Request/response bundle for the digit-serial ALU: operands and op in, result and SM83 flags out.
interface digit_serial_alu_if #(parameter int WIDTH = 8);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_h;
  logic             flag_c;

  modport master (output start, op, a, b, carry_in,
                  input  busy, done, result, flag_z, flag_n, flag_h, flag_c);
  modport slave  (input  start, op, a, b, carry_in,
                  output busy, done, result, flag_z, flag_n, flag_h, flag_c);
endinterface

// File: rtl/digit_serial_alu.sv
// Digit-serial ALU: WIDTH-bit operands, DIGIT bits per clock, LSD first, SM83 Z/N/H/C flags.
module digit_serial_alu #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4,
  parameter int HBIT  = 4
) (
  input logic              clk,
  input logic              reset,
  digit_serial_alu_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);
  localparam logic [CW-1:0] HIDX = CW'(HBIT / DIGIT - 1);

  localparam logic [2:0] OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_SBC = 3'd3,
                         OP_AND = 3'd4, OP_XOR = 3'd5, OP_OR  = 3'd6, OP_CP  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_sh, r_result;
  logic [2:0]       r_op;
  logic             r_cy, r_zacc, r_hraw;
  logic             r_z, r_n, r_h, r_c;

  logic             w_accept, w_last, w_sub, w_cin0, w_cout, w_zero;
  logic [DIGIT-1:0] w_da, w_db, w_dig;
  logic [DIGIT:0]   w_sum;
  logic [WIDTH-1:0] w_a_rot, w_res, w_final;
  logic             w_fn, w_fh, w_fc;

  assign w_accept = bus.start && (r_state != S_RUN);
  assign w_last   = (r_cnt == LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_ADC:        w_cin0 = bus.carry_in;
      OP_SUB, OP_CP: w_cin0 = 1'b1;
      OP_SBC:        w_cin0 = !bus.carry_in;
      default:       w_cin0 = 1'b0;
    endcase
  end

  // Operand A is rotated rather than shifted so CP can return it intact at the last digit.
  assign w_sub   = (r_op == OP_SUB) || (r_op == OP_SBC) || (r_op == OP_CP);
  assign w_da    = r_a[DIGIT-1:0];
  assign w_db    = w_sub ? ~r_b[DIGIT-1:0] : r_b[DIGIT-1:0];
  assign w_sum   = {1'b0, w_da} + {1'b0, w_db} + {{DIGIT{1'b0}}, r_cy};
  assign w_cout  = w_sum[DIGIT];
  assign w_a_rot = {w_da, r_a[WIDTH-1:DIGIT]};

  always_comb begin
    case (r_op)
      OP_AND:  w_dig = w_da & r_b[DIGIT-1:0];
      OP_XOR:  w_dig = w_da ^ r_b[DIGIT-1:0];
      OP_OR:   w_dig = w_da | r_b[DIGIT-1:0];
      default: w_dig = w_sum[DIGIT-1:0];
    endcase
  end

  assign w_res   = {w_dig, r_sh[WIDTH-1:DIGIT]};
  assign w_zero  = r_zacc && (w_dig == '0);
  assign w_final = (r_op == OP_CP) ? w_a_rot : w_res;

  always_comb begin
    w_fn = 1'b0;
    w_fh = 1'b0;
    w_fc = 1'b0;
    case (r_op)
      OP_ADD, OP_ADC: begin w_fh = r_hraw;  w_fc = w_cout;  end
      OP_SUB, OP_SBC, OP_CP: begin w_fn = 1'b1; w_fh = !r_hraw; w_fc = !w_cout; end
      OP_AND: w_fh = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sh     <= '0;
      r_op     <= OP_ADD;
      r_cy     <= 1'b0;
      r_zacc   <= 1'b0;
      r_hraw   <= 1'b0;
      r_result <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_h      <= 1'b0;
      r_c      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a    <= bus.a;
        r_b    <= bus.b;
        r_op   <= bus.op;
        r_cy   <= w_cin0;
        r_cnt  <= '0;
        r_zacc <= 1'b1;
        r_hraw <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_a    <= w_a_rot;
        r_b    <= r_b >> DIGIT;
        r_sh   <= w_res;
        r_cy   <= w_cout;
        r_zacc <= w_zero;
        r_cnt  <= r_cnt + 1'b1;
        if (r_cnt == HIDX) r_hraw <= w_cout;
        if (w_last) begin
          r_result <= w_final;
          r_z      <= w_zero;
          r_n      <= w_fn;
          r_h      <= w_fh;
          r_c      <= w_fc;
        end
      end
    end
  end

  assign bus.busy   = (r_state == S_RUN);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;
  assign bus.flag_z = r_z;
  assign bus.flag_n = r_n;
  assign bus.flag_h = r_h;
  assign bus.flag_c = r_c;
endmodule

// File: tb/tb_digit_serial_alu.sv
// Bench for digit_serial_alu: 8-bit and 16-bit instances against a cycle-level arithmetic model.
module tb_digit_serial_alu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  digit_serial_alu_if #(.WIDTH(8))  if8();
  digit_serial_alu_if #(.WIDTH(16)) if16();

  digit_serial_alu #(.WIDTH(8),  .DIGIT(4), .HBIT(4)) u_dut8  (.clk(clk), .reset(reset), .bus(if8));
  digit_serial_alu #(.WIDTH(16), .DIGIT(4), .HBIT(4)) u_dut16 (.clk(clk), .reset(reset), .bus(if16));

  logic        st[2];
  logic [2:0]  opv[2];
  logic [31:0] av[2], bv[2];
  logic        ci[2];
  logic        bsy_o[2], dn_o[2];
  logic [31:0] res_o[2];
  logic [3:0]  fl_o[2];

  assign if8.start    = st[0];
  assign if8.op       = opv[0];
  assign if8.a        = av[0][7:0];
  assign if8.b        = bv[0][7:0];
  assign if8.carry_in = ci[0];
  assign if16.start    = st[1];
  assign if16.op       = opv[1];
  assign if16.a        = av[1][15:0];
  assign if16.b        = bv[1][15:0];
  assign if16.carry_in = ci[1];
  assign bsy_o[0] = if8.busy;
  assign dn_o[0]  = if8.done;
  assign res_o[0] = {24'b0, if8.result};
  assign fl_o[0]  = {if8.flag_z, if8.flag_n, if8.flag_h, if8.flag_c};
  assign bsy_o[1] = if16.busy;
  assign dn_o[1]  = if16.done;
  assign res_o[1] = {16'b0, if16.result};
  assign fl_o[1]  = {if16.flag_z, if16.flag_n, if16.flag_h, if16.flag_c};

  int W[2]   = '{8, 16};
  int NDG[2] = '{2, 4};
  int HB[2]  = '{4, 4};

  int nchk = 0, nfail = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {z,n,h,c,result} from plain wide arithmetic.
  function automatic logic [35:0] model(input int w, input int hb, input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b, input logic ci);
    longint la = a, lb = b, mask = (64'd1 << w) - 1, hm = (64'd1 << hb) - 1, r = 0, k;
    logic n = 0, h = 0, c = 0, z;
    case (op)
      3'd0, 3'd1: begin
        k = (op == 3'd1) ? longint'(ci) : 0;
        r = (la + lb + k) & mask;
        c = ((la + lb + k) >> w) & 1;
        h = (((la & hm) + (lb & hm) + k) >> hb) & 1;
      end
      3'd2, 3'd3, 3'd7: begin
        k = (op == 3'd3) ? longint'(ci) : 0;
        r = (la - lb - k) & mask;
        c = la < lb + k;
        h = (la & hm) < (lb & hm) + k;
        n = 1;
      end
      3'd4: begin r = la & lb; h = 1; end
      3'd5: r = la ^ lb;
      default: r = la | lb;
    endcase
    z = (r == 0);
    if (op == 3'd7) r = la;
    return {z, n, h, c, r[31:0]};
  endfunction

  int          mk[2]   = '{0, 0};
  logic        mdone[2] = '{0, 0};
  logic [35:0] pend[2], mexp[2] = '{36'd0, 36'd0};

  // Timing model: NDIG busy cycles after accept, then one done cycle that may re-accept.
  always @(posedge clk) begin
    started = 1;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mk[d] = 0; mdone[d] = 0; mexp[d] = '0;
      end else if (mk[d] > 0) begin
        mk[d]--;
        mdone[d] = (mk[d] == 0);
        if (mk[d] == 0) mexp[d] = pend[d];
      end else begin
        mdone[d] = 0;
        if (st[d]) begin
          pend[d] = model(W[d], HB[d], opv[d], av[d], bv[d], ci[d]);
          mk[d] = NDG[d];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy%0d", d), {35'd0, bsy_o[d]}, {35'd0, mk[d] > 0});
        chk($sformatf("done%0d", d), {35'd0, dn_o[d]}, {35'd0, mdone[d]});
        chk($sformatf("result%0d", d), {4'd0, res_o[d]}, {4'd0, mexp[d][31:0]});
        chk($sformatf("flags%0d", d), {32'd0, fl_o[d]}, {32'd0, mexp[d][35:32]});
      end
    end
  end

  task automatic wait_done(input int d, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!dn_o[d] && n < 50);
    if (n >= 50) chk("done_timeout", 36'd1, 36'd0);
  endtask

  task automatic run(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic c, input logic [31:0] er, input logic [3:0] ef, input string nm);
    int n;
    @(negedge clk);
    st[d] = 1; opv[d] = op; av[d] = a; bv[d] = b; ci[d] = c;
    @(posedge clk); #1;
    st[d] = 0;
    chk({nm, "_busy"}, {35'd0, bsy_o[d]}, 36'd1);
    wait_done(d, n);
    chk({nm, "_lat"}, 36'(n), 36'(NDG[d]));
    chk({nm, "_res"}, {4'd0, res_o[d]}, {4'd0, er});
    chk({nm, "_zнhc"}, {32'd0, fl_o[d]}, {32'd0, ef});
  endtask

  initial begin
    int n, m, cnt;
    for (int d = 0; d < 2; d++) begin
      st[d] = 0; opv[d] = 0; av[d] = 0; bv[d] = 0; ci[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {35'd0, bsy_o[0]}, 36'd0);
    chk("rst_res", {4'd0, res_o[0]}, 36'd0);
    chk("rst_flags", {32'd0, fl_o[0]}, 36'd0);
    @(negedge clk); reset = 0;

    run(0, 3'd0, 32'h3A, 32'hC6, 0, 32'h00, 4'b1011, "add");
    run(0, 3'd2, 32'h10, 32'h01, 0, 32'h0F, 4'b0110, "sub");
    run(0, 3'd3, 32'h00, 32'h00, 1, 32'hFF, 4'b0111, "sbc");
    run(0, 3'd4, 32'hF0, 32'h0F, 0, 32'h00, 4'b1010, "and");
    run(0, 3'd7, 32'h42, 32'h42, 0, 32'h42, 4'b1100, "cp");
    run(0, 3'd5, 32'hA5, 32'hFF, 0, 32'h5A, 4'b0000, "xor");
    run(0, 3'd6, 32'h00, 32'h00, 0, 32'h00, 4'b1000, "or");
    run(1, 3'd0, 32'h0FFF, 32'h0001, 0, 32'h1000, 4'b0010, "add16");
    run(1, 3'd2, 32'h1000, 32'h0001, 0, 32'h0FFF, 4'b0110, "sub16");

    // Back-to-back with start held through the done cycle.
    @(negedge clk);
    st[0] = 1; opv[0] = 3'd1; av[0] = 32'hFF; bv[0] = 32'h00; ci[0] = 1;
    @(posedge clk); #1;
    opv[0] = 3'd0; av[0] = 32'h01; bv[0] = 32'h01; ci[0] = 0;
    wait_done(0, n);
    chk("b2b1_lat", 36'(n), 36'd2);
    chk("b2b1_res", {4'd0, res_o[0]}, 36'h00);
    chk("b2b1_flags", {32'd0, fl_o[0]}, 36'b1011);
    m = 0;
    do begin
      @(posedge clk); #1; m++;
      if (m == 1) st[0] = 0;
    end while (!dn_o[0] && m < 50);
    chk("b2b2_gap", 36'(m), 36'd3);
    chk("b2b2_res", {4'd0, res_o[0]}, 36'h02);
    chk("b2b2_flags", {32'd0, fl_o[0]}, 36'b0000);

    // start pulsed mid-RUN must be ignored.
    @(negedge clk);
    st[0] = 1; opv[0] = 3'd0; av[0] = 32'h05; bv[0] = 32'h03; ci[0] = 0;
    @(posedge clk); #1; st[0] = 0;
    @(posedge clk); #1; st[0] = 1;
    @(posedge clk); #1; st[0] = 0;
    chk("ign_done", {35'd0, dn_o[0]}, 36'd1);
    chk("ign_res", {4'd0, res_o[0]}, 36'h08);
    cnt = 0;
    repeat (5) begin @(posedge clk); #1; if (dn_o[0]) cnt++; end
    chk("ign_extra", 36'(cnt), 36'd0);

    // Reset on the first RUN cycle aborts.
    @(negedge clk);
    st[0] = 1; opv[0] = 3'd0; av[0] = 32'h12; bv[0] = 32'h34; ci[0] = 0;
    @(posedge clk); #1; st[0] = 0; reset = 1;
    @(posedge clk); #1; reset = 0;
    chk("abort_busy", {35'd0, bsy_o[0]}, 36'd0);
    chk("abort_res", {4'd0, res_o[0]}, 36'd0);
    chk("abort_flags", {32'd0, fl_o[0]}, 36'd0);
    cnt = 0;
    repeat (5) begin @(posedge clk); #1; if (dn_o[0]) cnt++; end
    chk("abort_nodone", 36'(cnt), 36'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
